// File: rtl/audio_viz_pkg.sv
// Shared types and helpers for the audio visualizer datapath.
//
//   DEFAULT_SAMPLE_WIDTH  signed sample width used by the framer by default
//   sample_t              signed sample of DEFAULT_SAMPLE_WIDTH bits
//   mag_t                 unsigned magnitude, one bit narrower than sample_t
//   stereo_t              {left, right} sample pair, left in the MSBs
//   peak_state_t          ACCUM / EMIT states of the peak window tracker
//   sat_abs()             saturating absolute value, sample_t -> mag_t
package audio_viz_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;

    typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;
    typedef logic        [DEFAULT_SAMPLE_WIDTH-2:0] mag_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } peak_state_t;

    // The most negative sample has no positive counterpart in mag_t, so it
    // clamps to the largest magnitude instead of wrapping to zero.
    function automatic mag_t sat_abs(input sample_t x);
        sample_t neg;
        mag_t    res;
        neg = -x;
        if (x == {1'b1, {(DEFAULT_SAMPLE_WIDTH-1){1'b0}}})
            res = '1;
        else if (x[DEFAULT_SAMPLE_WIDTH-1])
            res = neg[DEFAULT_SAMPLE_WIDTH-2:0];
        else
            res = x[DEFAULT_SAMPLE_WIDTH-2:0];
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
//
//   clk, reset  clock and synchronous active-high reset (flushes contents)
//   push, din   write request and data; accepted when not full, or when full
//               and a pop happens in the same cycle
//   pop         read request; ignored while empty
//   dout        head word (registered), valid while !empty
//   empty/full  occupancy flags
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_plus1;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             pop_ok, push_ok;

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign pop_ok       = pop && !empty;
    assign push_ok      = push && (!full || pop_ok);
    assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);
    assign dout         = head_reg;

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_plus1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + ONE_CNT;
                2'b01:   count_reg <= count_reg - ONE_CNT;
                default: count_reg <= count_reg;
            endcase
            // A write into an empty FIFO (or one being emptied this cycle)
            // bypasses the array so the head is valid on the next cycle.
            if (push_ok && (empty || (pop_ok && count_reg == ONE_CNT)))
                head_reg <= din;
            else if (pop_ok && count_reg > ONE_CNT)
                head_reg <= mem[rd_ptr_plus1];
        end
    end

endmodule

// File: rtl/i2s_sample_framer.sv
// Stereo frame capture, FIFO buffering and windowed peak metering for the
// samples coming out of the I2S receiver.
//
//   clk, reset              system clock, synchronous active-high reset
//   ws                      word select; a 0->1 transition marks a completed frame
//   data_left, data_right   receiver words, sampled on the frame-event edge
//   m_data/m_valid/m_ready  {left,right} FIFO output, left in the MSBs
//   peak_left, peak_right   windowed absolute peaks, held between pulses
//   peak_valid              one-cycle pulse when a new peak pair is shown
//   overflow, ovf_clr       sticky frame-drop flag and its clear
//
// Optional feature macro: LEVEL_DECAY_EN. When defined, each new peak is
// max(window peak, old peak - (old peak >> DECAY_SHIFT)) for smooth bar
// fall-off; otherwise the raw window peak is shown.
module i2s_sample_framer
    import audio_viz_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH    = 8,
    parameter int WINDOW_FRAMES = 4,
    parameter int DECAY_SHIFT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ws,
    input  logic [DATA_WIDTH-1:0]     data_left,
    input  logic [DATA_WIDTH-1:0]     data_right,
    output logic [2*SAMPLE_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SAMPLE_WIDTH-2:0]   peak_left,
    output logic [SAMPLE_WIDTH-2:0]   peak_right,
    output logic                      peak_valid,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    localparam int MW = SAMPLE_WIDTH - 1;
    localparam int CW = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW_FRAMES - 1);

    logic ws_d_reg;
    logic frame_event;
    logic fifo_empty, fifo_full, drop;
    logic overflow_reg;

    // Channel 0 is left, channel 1 is right throughout.
    logic signed [SAMPLE_WIDTH-1:0] sample [2];
    logic [MW-1:0] mag       [2];
    logic [MW-1:0] acc_reg   [2];
    logic [MW-1:0] acc_next  [2];
    logic [MW-1:0] acc_max   [2];
    logic [MW-1:0] new_peak  [2];
    logic [MW-1:0] peak_reg  [2];
    logic [MW-1:0] peak_next [2];

    peak_state_t   state_reg, state_next;
    logic [CW-1:0] win_cnt_reg, win_cnt_next;

    // ws_d resets high so a ws already high at reset release is not a frame.
    assign frame_event = ws && !ws_d_reg;

    assign sample[0] = data_left[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign sample[1] = data_right[DATA_WIDTH-1 -: SAMPLE_WIDTH];

    generate
        if (DATA_WIDTH > SAMPLE_WIDTH) begin : g_lsb
            logic lsb_unused;
            assign lsb_unused = ^{data_left[DATA_WIDTH-SAMPLE_WIDTH-1:0],
                                  data_right[DATA_WIDTH-SAMPLE_WIDTH-1:0]};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            if (SAMPLE_WIDTH == DEFAULT_SAMPLE_WIDTH) begin : g_pkg_abs
                assign mag[gi] = sat_abs(sample[gi]);
            end else begin : g_abs
                logic signed [SAMPLE_WIDTH-1:0] neg;
                assign neg = -sample[gi];
                assign mag[gi] = (sample[gi] == {1'b1, {MW{1'b0}}}) ? {MW{1'b1}} :
                                 sample[gi][MW] ? neg[MW-1:0] : sample[gi][MW-1:0];
            end

            assign acc_max[gi] = (mag[gi] > acc_reg[gi]) ? mag[gi] : acc_reg[gi];

`ifdef LEVEL_DECAY_EN
            // The shifted term never exceeds the peak, so this cannot underflow.
            logic [MW-1:0] decayed;
            assign decayed      = peak_reg[gi] - (peak_reg[gi] >> DECAY_SHIFT);
            assign new_peak[gi] = (acc_max[gi] > decayed) ? acc_max[gi] : decayed;
`else
            assign new_peak[gi] = acc_max[gi];
`endif
        end
    endgenerate

`ifndef LEVEL_DECAY_EN
    localparam int decay_unused = DECAY_SHIFT;
`endif

    sync_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (frame_event),
        .din   ({sample[0], sample[1]}),
        .pop   (m_ready),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_valid = !fifo_empty;
    // A pop in the same cycle makes room, so only a stalled full FIFO drops.
    assign drop    = frame_event && fifo_full && !m_ready;

    always_comb begin
        state_next   = state_reg;
        win_cnt_next = win_cnt_reg;
        acc_next     = acc_reg;
        peak_next    = peak_reg;
        case (state_reg)
            ST_ACCUM: begin
                if (frame_event) begin
                    if (win_cnt_reg == LAST_CNT) begin
                        peak_next    = new_peak;
                        acc_next     = '{default: '0};
                        win_cnt_next = '0;
                        state_next   = ST_EMIT;
                    end else begin
                        acc_next     = acc_max;
                        win_cnt_next = win_cnt_reg + CW'(1);
                    end
                end
            end
            ST_EMIT: state_next = ST_ACCUM;
            default: state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_d_reg     <= 1'b1;
            state_reg    <= ST_ACCUM;
            win_cnt_reg  <= '0;
            acc_reg      <= '{default: '0};
            peak_reg     <= '{default: '0};
            overflow_reg <= 1'b0;
        end else begin
            ws_d_reg     <= ws;
            state_reg    <= state_next;
            win_cnt_reg  <= win_cnt_next;
            acc_reg      <= acc_next;
            peak_reg     <= peak_next;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    assign peak_left  = peak_reg[0];
    assign peak_right = peak_reg[1];
    assign peak_valid = (state_reg == ST_EMIT);
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_i2s_sample_framer.sv
module tb_i2s_sample_framer;

    localparam int DW    = 32;
    localparam int SW    = 24;
    localparam int DEPTH = 8;
    localparam int WIN   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ws = 1'b1;
    logic [DW-1:0] data_left = '0;
    logic [DW-1:0] data_right = '0;
    logic [2*SW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [SW-2:0] peak_left, peak_right;
    logic          peak_valid;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_count = 0;
    bit chk_en   = 0;
    bit rand_mode = 0;

    i2s_sample_framer #(
        .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH),
        .WINDOW_FRAMES(WIN), .DECAY_SHIFT(1)
    ) dut (
        .clk(clk), .reset(reset), .ws(ws),
        .data_left(data_left), .data_right(data_right),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .peak_left(peak_left), .peak_right(peak_right), .peak_valid(peak_valid),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [2*SW-1:0] q[$];
    int   win_l[$], win_r[$];
    bit   ws_prev;
    bit   m_ovf, m_pv;
    int   m_pk_l, m_pk_r;

    function automatic int absv(input logic [DW-1:0] d);
        int v;
        logic signed [SW-1:0] s;
        s = d[DW-1 -: SW];
        v = s;
        if (v < 0) v = -v;
        if (v > (1 << (SW-1)) - 1) v = (1 << (SW-1)) - 1;
        return v;
    endfunction

    function automatic int qmax(input int w[$]);
        int m = 0;
        foreach (w[i]) if (w[i] > m) m = w[i];
        return m;
    endfunction

    function automatic int next_peak(input int cand, input int old);
        int p = cand;
`ifdef LEVEL_DECAY_EN
        if (old - old / 2 > p) p = old - old / 2;
`endif
        return p;
    endfunction

    always @(posedge clk) begin
        bit ev, pop, drop;
        if (reset) begin
            q.delete(); win_l.delete(); win_r.delete();
            ws_prev = 1; m_ovf = 0; m_pv = 0; m_pk_l = 0; m_pk_r = 0;
        end else begin
            m_pv = 0;
            ev   = ws && !ws_prev;
            pop  = (q.size() > 0) && m_ready;
            drop = ev && (q.size() == DEPTH) && !pop;
            if (pop) void'(q.pop_front());
            if (ev && !drop) q.push_back({data_left[DW-1 -: SW], data_right[DW-1 -: SW]});
            if (drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (ev) begin
                win_l.push_back(absv(data_left));
                win_r.push_back(absv(data_right));
                if (win_l.size() == WIN) begin
                    m_pk_l = next_peak(qmax(win_l), m_pk_l);
                    m_pk_r = next_peak(qmax(win_r), m_pk_r);
                    m_pv = 1;
                    win_l.delete(); win_r.delete();
                end
            end
            ws_prev = ws;
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", 64'(m_valid), 64'(q.size() != 0));
            if (q.size() != 0) check("m_data", 64'(m_data), 64'(q[0]));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("peak_valid", 64'(peak_valid), 64'(m_pv));
            check("peak_left", 64'(peak_left), 64'(m_pk_l));
            check("peak_right", 64'(peak_right), 64'(m_pk_r));
            if (peak_valid) pv_count++;
        end
    end

    always @(negedge clk) begin
        if (rand_mode) begin
            m_ready = 1'($urandom_range(0, 1));
            ovf_clr = ($urandom_range(0, 15) == 0);
        end
    end

    // ---------------- stimulus ----------------
    // Returns just after the frame-event edge; ws stays high until the next call.
    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int gap, input bit rdy_at_event);
        @(negedge clk);
        data_left = l; data_right = r; ws = 1'b0;
        repeat (gap) @(negedge clk);
        ws = 1'b1;
        if (rdy_at_event) m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ws = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] w(input logic [SW-1:0] s);
        return {s, 8'h00};
    endfunction

    initial begin
        logic [22:0] decay_exp;
        // Test 1: ws high across reset release -> nothing happens.
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t1_m_valid", 64'(m_valid), 64'd0);
        check("t1_m_data", 64'(m_data), 64'd0);
        check("t1_peak_valid", 64'(peak_valid), 64'd0);
        check("t1_peak_left", 64'(peak_left), 64'd0);
        check("t1_overflow", 64'(overflow), 64'd0);

        // Test 2: truncation and first-word latency.
        send_frame(32'h7FFFFF00, 32'h80000000, 2, 0);
        check("t2_m_valid", 64'(m_valid), 64'd1);
        check("t2_m_data", 64'(m_data), 64'h7FFFFF800000);

        // Test 3: window peak with saturating abs.
        do_reset();
        m_ready = 1'b1;
        send_frame(w(24'h000010), '0, 2, 0);
        send_frame(w(24'hFFFFF0), '0, 2, 0);
        send_frame(w(24'h000020), '0, 2, 0);
        send_frame(w(24'h800000), '0, 2, 0);
        check("t3_peak_valid", 64'(peak_valid), 64'd1);
        check("t3_peak_left", 64'(peak_left), 64'h7FFFFF);
        check("t3_peak_right", 64'(peak_right), 64'd0);
        for (int i = 0; i < WIN; i++) send_frame('0, '0, 2, 0);
`ifdef LEVEL_DECAY_EN
        decay_exp = 23'h400000;
`else
        decay_exp = 23'h000000;
`endif
        check("t3_peak_left_next", 64'(peak_left), 64'(decay_exp));

        // Test 4: overflow with a stalled consumer, ordered drain, clear.
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(w(24'(i)), w(24'(100 + i)), 2, 0);
        check("t4_overflow", 64'(overflow), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t4_drain_valid", 64'(m_valid), 64'd1);
            check("t4_drain_left", 64'(m_data[2*SW-1 -: SW]), 64'(i));
            m_ready = 1'b1;
        end
        @(negedge clk);
        check("t4_empty", 64'(m_valid), 64'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 64'(overflow), 64'd0);

        // Test 5: full FIFO with a pop in the event cycle accepts the frame.
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_frame(w(24'(i)), '0, 2, 0);
        send_frame(w(24'd9), '0, 2, 1);
        m_ready = 1'b0;
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_head", 64'(m_data[2*SW-1 -: SW]), 64'd2);
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk);
            check("t5_drain_left", 64'(m_data[2*SW-1 -: SW]), 64'(i));
            m_ready = 1'b1;
        end
        @(negedge clk);
        check("t5_empty", 64'(m_valid), 64'd0);

        // Test 6: reset mid-window discards the partial window.
        do_reset();
        m_ready = 1'b1;
        send_frame(w(24'h700000), '0, 2, 0);
        send_frame(w(24'h700000), '0, 2, 0);
        do_reset();
        pv_count = 0;
        send_frame(w(24'h000010), '0, 2, 0);
        send_frame(w(24'h000020), '0, 2, 0);
        send_frame(w(24'hFFFFD0), '0, 2, 0);
        send_frame(w(24'h000005), '0, 2, 0);
        repeat (3) @(negedge clk);
        check("t6_pv_count", 64'(pv_count), 64'd1);
        check("t6_peak_left", 64'(peak_left), 64'h30);

        // Randomized phase, checked by the compare process.
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 120; i++) begin
            logic [DW-1:0] l, r;
            case ($urandom_range(0, 3))
                0: l = 32'h80000000;
                1: l = 32'h7FFFFFFF;
                default: l = $urandom;
            endcase
            r = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            send_frame(l, r, $urandom_range(2, 5), 0);
        end
        repeat (20) @(negedge clk);
        rand_mode = 0;
        m_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
